tank_sprite_renderer: RTL and testbench

TANK_SPRITE_RENDERER -- requirements
Module: tank_sprite_renderer

---
 rtl/tank_pkg.sv | 23 ++
 rtl/tank_addr_gen.sv | 66 ++++++
 rtl/tank_sprite_renderer.sv | 77 +++++++
 tb/tb_tank_sprite_renderer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared constants and types for the tank sprite renderer.
// Sprite geometry, ROM depth, facing encoding and the 16-entry palette.
package tank_pkg;

  localparam int SPRITE_DIM = 50;
  localparam int ROM_DEPTH  = 2500;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } tank_dir_e;

  // Index 0 is never displayed (transparent).
  localparam logic [0:15][23:0] PALETTE = {
    24'h000000, 24'h1e3a14, 24'h2f5a1f, 24'h467a2c,
    24'h5c9a3a, 24'h7fb850, 24'ha4d46c, 24'h3b3b3b,
    24'h5e5e5e, 24'h8a8a8a, 24'hc0c0c0, 24'h6b4a22,
    24'h8f6a34, 24'hd8b060, 24'hff4020, 24'hffffff
  };

endpackage

// File: rtl/tank_addr_gen.sv
// Bounds check and sprite ROM address transform (combinational).
// With TANK_ROTATE_EN defined, one right-facing ROM is rotated per facing.
module tank_addr_gen
  import tank_pkg::*;
(
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
`ifdef TANK_ROTATE_EN
  input  tank_dir_e   dir,
`endif
  output logic        in_bounds,
  output logic [11:0] addr
);

  localparam logic [10:0] DIM  = 11'(SPRITE_DIM);
  localparam logic [5:0]  LAST = 6'(SPRITE_DIM - 1);

  logic [10:0] dx, dy, x0, y0;
  logic [5:0]  c, r, src_r, src_c;

  // 11-bit compare so a sprite near 1023 does not wrap to 0.
  assign dx = {1'b0, draw_x};
  assign dy = {1'b0, draw_y};
  assign x0 = {1'b0, pos_x};
  assign y0 = {1'b0, pos_y};

  assign in_bounds = (dx >= x0) && (dx < x0 + DIM) &&
                     (dy >= y0) && (dy < y0 + DIM);

  assign c = draw_x[5:0] - pos_x[5:0];
  assign r = draw_y[5:0] - pos_y[5:0];

  always_comb begin
    src_r = r;
    src_c = c;
`ifdef TANK_ROTATE_EN
    unique case (dir)
      DIR_RIGHT: begin
        src_r = r;
        src_c = c;
      end
      DIR_LEFT: begin
        src_r = r;
        src_c = LAST - c;
      end
      DIR_UP: begin
        src_r = c;
        src_c = LAST - r;
      end
      DIR_DOWN: begin
        src_r = LAST - c;
        src_c = r;
      end
      default: begin
        src_r = r;
        src_c = c;
      end
    endcase
`endif
  end

  assign addr = 12'(src_r) * 12'(SPRITE_DIM) + 12'(src_c);

endmodule

// File: rtl/tank_sprite_renderer.sv
// Tank sprite renderer: frame-buffered position, 2-stage pixel pipeline.
// Optional macro TANK_ROTATE_EN selects one rotated ROM instead of rom_sel.
module tank_sprite_renderer
  import tank_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  tank_x,
  input  logic [9:0]  tank_y,
  input  logic [1:0]  tank_dir,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pix_in_valid,
  output logic [18:0] read_address,
  output logic [1:0]  rom_sel,
  input  logic [4:0]  rom_data,
  output logic        pix_out_valid,
  output logic        pix_hit,
  output logic [23:0] rgb
);

  logic [9:0]  active_x, active_y;
  tank_dir_e   active_dir;
  logic        in_b, s1_inb, s1_valid;
  logic [11:0] addr_c;
  logic        opaque, hit_c;

  tank_addr_gen u_addr (
    .draw_x    (DrawX),
    .draw_y    (DrawY),
    .pos_x     (active_x),
    .pos_y     (active_y),
`ifdef TANK_ROTATE_EN
    .dir       (active_dir),
`endif
    .in_bounds (in_b),
    .addr      (addr_c)
  );

  // Bit 4 of the frame RAM word carries no colour information.
  assign opaque = |(rom_data & 5'h0f);
  assign hit_c  = s1_inb & s1_valid & opaque;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      active_x      <= '0;
      active_y      <= '0;
      active_dir    <= DIR_RIGHT;
      read_address  <= '0;
      rom_sel       <= '0;
      s1_inb        <= 1'b0;
      s1_valid      <= 1'b0;
      pix_out_valid <= 1'b0;
      pix_hit       <= 1'b0;
      rgb           <= '0;
    end else begin
      if (frame_start) begin
        active_x   <= tank_x;
        active_y   <= tank_y;
        active_dir <= tank_dir_e'(tank_dir);
      end
      s1_valid     <= pix_in_valid;
      s1_inb       <= in_b;
      read_address <= (in_b & pix_in_valid) ? 19'(addr_c) : '0;
`ifdef TANK_ROTATE_EN
      rom_sel      <= 2'b00;
`else
      rom_sel      <= active_dir;
`endif
      pix_out_valid <= s1_valid;
      pix_hit       <= hit_c;
      rgb           <= hit_c ? PALETTE[rom_data[3:0]] : '0;
    end
  end

endmodule

// File: tb/tb_tank_sprite_renderer.sv
// Self-checking bench for tank_sprite_renderer.
// Directed vector table, reset sequence, then randomised scoreboard run.
module tb_tank_sprite_renderer;
  import tank_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, frame_start, pix_in_valid;
  logic [9:0]  tank_x, tank_y, DrawX, DrawY;
  logic [1:0]  tank_dir;
  logic [18:0] read_address;
  logic [1:0]  rom_sel;
  logic [4:0]  rom_data;
  logic        pix_out_valid, pix_hit;
  logic [23:0] rgb;

  always #5 Clk = ~Clk;

  tank_sprite_renderer dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_start   (frame_start),
    .tank_x        (tank_x),
    .tank_y        (tank_y),
    .tank_dir      (tank_dir),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .pix_in_valid  (pix_in_valid),
    .read_address  (read_address),
    .rom_sel       (rom_sel),
    .rom_data      (rom_data),
    .pix_out_valid (pix_out_valid),
    .pix_hit       (pix_hit),
    .rgb           (rgb)
  );

  logic [3:0] rom_mem [2500];

  always_comb begin
    rom_data = 5'h10;
    if (read_address < 19'd2500)
      rom_data = {1'b1, rom_mem[int'(read_address)]};
  end

  typedef struct {
    logic [18:0] addr;
    logic [1:0]  sel;
    logic        pov;
    logic        hit;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    logic        rst, fs;
    logic [9:0]  tx, ty;
    logic [1:0]  dir;
    logic [9:0]  dx, dy;
    logic        v;
    int          a, ar;
    logic [1:0]  sel;
    logic        hit;
  } vec_t;

  exp_t q[$];
  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  logic [9:0] m_x, m_y;
  logic [1:0] m_dir;

  function automatic exp_t null_exp();
    exp_t e;
    e.addr = '0; e.sel = '0; e.pov = 1'b0; e.hit = 1'b0; e.rgb = '0;
    return e;
  endfunction

  function automatic exp_t mk(int a, logic [1:0] s, logic v, logic h);
    exp_t e;
    e.addr = 19'(a);
    e.sel  = s;
    e.pov  = v;
    e.hit  = h;
    e.rgb  = h ? PALETTE[rom_mem[a]] : 24'h0;
    return e;
  endfunction

  // Reference model working in plain integers on the bench's own copy of
  // the buffered position.
  function automatic exp_t model(logic [9:0] dx, logic [9:0] dy, logic v);
    int c, r, sr, sc, a;
    logic inb;
    c = int'(dx) - int'(m_x);
    r = int'(dy) - int'(m_y);
    inb = v && c >= 0 && c < 50 && r >= 0 && r < 50;
    sr = r;
    sc = c;
`ifdef TANK_ROTATE_EN
    case (m_dir)
      2'd1: sc = 49 - c;
      2'd2: begin sr = c; sc = 49 - r; end
      2'd3: begin sr = 49 - c; sc = r; end
      default: ;
    endcase
`endif
    a = inb ? sr * 50 + sc : 0;
`ifdef TANK_ROTATE_EN
    return mk(a, 2'd0, v, inb && rom_mem[a] != 4'd0);
`else
    return mk(a, m_dir, v, inb && rom_mem[a] != 4'd0);
`endif
  endfunction

  function automatic vec_t V(logic rst, logic fs, int tx, int ty, int dir,
                             int dx, int dy, logic v, int a, int ar,
                             int sel, logic hit);
    vec_t t;
    t.rst = rst; t.fs = fs;
    t.tx = 10'(tx); t.ty = 10'(ty); t.dir = 2'(dir);
    t.dx = 10'(dx); t.dy = 10'(dy); t.v = v;
    t.a = a; t.ar = ar; t.sel = 2'(sel); t.hit = hit;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("pix_out_valid", 32'(pix_out_valid), 32'(e.pov));
      chk("pix_hit", 32'(pix_hit), 32'(e.hit));
      chk("rgb", 32'(rgb), 32'(e.rgb));
    end
    if (q.size() == 1) begin
      chk("read_address", 32'(read_address), 32'(q[0].addr));
      chk("rom_sel", 32'(rom_sel), 32'(q[0].sel));
    end
  endtask

  task automatic step(logic rst, logic fs, logic [9:0] tx, logic [9:0] ty,
                      logic [1:0] dir, logic [9:0] dx, logic [9:0] dy,
                      logic v, exp_t e);
    @(negedge Clk);
    check_outputs();
    Reset        = rst;
    frame_start  = fs;
    tank_x       = tx;
    tank_y       = ty;
    tank_dir     = dir;
    DrawX        = dx;
    DrawY        = dy;
    pix_in_valid = v;
    if (rst) begin
      foreach (q[i]) q[i] = null_exp();
      e = null_exp();
      m_x = '0; m_y = '0; m_dir = '0;
    end else if (fs) begin
      m_x = tx; m_y = ty; m_dir = dir;
    end
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic [9:0] rx, ry;
    Reset = 1'b1; frame_start = 1'b0; pix_in_valid = 1'b0;
    tank_x = '0; tank_y = '0; tank_dir = '0; DrawX = '0; DrawY = '0;
    m_x = '0; m_y = '0; m_dir = '0;

    for (int i = 0; i < 2500; i++) rom_mem[i] = 4'((i % 15) + 1);
    rom_mem[0]    = 4'd5;
    rom_mem[1]    = 4'd0;
    rom_mem[49]   = 4'd3;
    rom_mem[2450] = 4'd7;
    rom_mem[2499] = 4'd9;

    // rst fs tx ty dir dx dy v | addr addr_rot sel hit
    tbl.push_back(V(0,1, 100,200,0,    0,   0,0,    0,   0,0,0));
    tbl.push_back(V(0,0, 100,200,0,  100, 200,1,    0,   0,0,1));
    tbl.push_back(V(0,0, 100,200,0,  149, 249,1, 2499,2499,0,1));
    tbl.push_back(V(0,0, 100,200,0,  150, 249,1,    0,   0,0,0));
    tbl.push_back(V(0,0, 100,200,0,  101, 200,1,    1,   1,0,0));
    tbl.push_back(V(0,0, 100,200,0,   99, 200,1,    0,   0,0,0));
    tbl.push_back(V(0,0, 100,200,0,  100, 250,1,    0,   0,0,0));
    tbl.push_back(V(0,0, 300,200,0,  100, 200,1,    0,   0,0,1));
    tbl.push_back(V(0,0, 300,200,0,  300, 200,1,    0,   0,0,0));
    tbl.push_back(V(0,1, 300,200,3,  100, 200,1,    0,   0,0,1));
    tbl.push_back(V(0,0, 300,200,3,  300, 200,1,    0,2450,3,1));
    tbl.push_back(V(0,1, 300,200,1,    0,   0,0,    0,   0,3,0));
    tbl.push_back(V(0,0, 300,200,1,  300, 200,1,    0,  49,1,1));
    tbl.push_back(V(0,0, 300,200,1,  349, 249,1, 2499,2450,1,1));
    tbl.push_back(V(0,1,1000,1000,0,   0,   0,0,    0,   0,1,0));
    tbl.push_back(V(0,0,1000,1000,0,1023,1023,1, 1173,1173,0,1));
    tbl.push_back(V(0,0,1000,1000,0,   0,   0,1,    0,   0,0,0));
    tbl.push_back(V(0,0,1000,1000,0,1023,1023,0,    0,   0,0,0));

    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, null_exp());

    foreach (tbl[i]) begin
`ifdef TANK_ROTATE_EN
      e = mk(tbl[i].ar, 2'd0, tbl[i].v, tbl[i].hit);
`else
      e = mk(tbl[i].a, tbl[i].sel, tbl[i].v, tbl[i].hit);
`endif
      step(tbl[i].rst, tbl[i].fs, tbl[i].tx, tbl[i].ty, tbl[i].dir,
           tbl[i].dx, tbl[i].dy, tbl[i].v, e);
    end

    // Reset with hits in flight, then confirm the position is back at 0.
    step(0, 1, 10, 10, 2, 0, 0, 0, model(0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      rx = 10'(10 + i);
      step(0, 0, 10, 10, 2, rx, 10, 1, model(rx, 10, 1));
    end
    step(1, 0, 10, 10, 2, 14, 10, 1, null_exp());
    step(1, 0, 10, 10, 2, 15, 10, 1, null_exp());
    step(0, 0, 10, 10, 2, 0, 0, 1, mk(0, 2'd0, 1'b1, 1'b1));
    step(0, 0, 10, 10, 2, 5, 3, 1, mk(155, 2'd0, 1'b1, 1'b1));
    step(0, 0, 10, 10, 2, 12, 10, 1, model(12, 10, 1));

    // Randomised run against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic rst, fs, v;
      logic [9:0] tx, ty;
      logic [1:0] dir;
      rst = ($urandom_range(0, 79) == 0);
      fs  = ($urandom_range(0, 15) == 0);
      v   = ($urandom_range(0, 3) != 0);
      tx  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(970, 1023))
                                        : 10'($urandom_range(0, 1023));
      ty  = 10'($urandom_range(0, 1023));
      dir = 2'($urandom_range(0, 3));
      rx  = m_x + 10'($urandom_range(0, 60)) - 10'd5;
      ry  = m_y + 10'($urandom_range(0, 60)) - 10'd5;
      step(rst, fs, tx, ty, dir, rx, ry, v, model(rx, ry, v));
    end

    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, model(0, 0, 0));
    @(negedge Clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
